// File: rtl/io_seq_checker.sv
// io_seq_checker
// Watches an asynchronous bus and checks that it steps, in order, through a
// programmed table of expected values. Each table entry is compared under a
// bit mask. Values that do not match are ignored. An optional per-step
// timeout ends the check in FAIL.
//
// Ports:
//   i_clk, i_nrst            clock; asynchronous active-low reset
//   i_wr_en/i_wr_addr/i_wr_data
//                            expected-value table write (ignored while running)
//   i_seq_len/i_mask/i_timeout
//                            check setup, captured when a check starts
//   i_start, i_abort         begin a check / return to idle (abort wins)
//   i_bus_in                 monitored pins, synchronised internally
//   o_busy/o_pass/o_fail     status; at most one high, none in idle
//   o_step                   number of entries matched so far
//   o_match_stb              one-cycle pulse per matched entry
//
// state  | meaning
// S_IDLE | no check in progress, table writable
// S_RUN  | comparing synchronised bus against table[step]
// S_PASS | all seq_len entries matched, held until start/abort
// S_FAIL | a step timed out, held until start/abort
module io_seq_checker #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int TMO_W = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW:0]      i_seq_len,
    input  logic [WIDTH-1:0] i_mask,
    input  logic [TMO_W-1:0] i_timeout,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_bus_in,
    output logic             o_busy,
    output logic             o_pass,
    output logic             o_fail,
    output logic [AW:0]      o_step,
    output logic             o_match_stb
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_sync1, r_sync2;
    logic [WIDTH-1:0] r_tab [DEPTH];
    logic [AW:0]      r_step, w_step_nx;
    logic [AW:0]      r_len, w_len_nx;
    logic [WIDTH-1:0] r_mask, w_mask_nx;
    logic [TMO_W-1:0] r_tmo, w_tmo_nx;
    // Down-counter holding the cycles left in the current step.
    logic [TMO_W-1:0] r_tmr, w_tmr_nx;
    logic             r_stb, w_stb_nx;

    logic [AW-1:0]    w_idx;
    logic             w_hit;
    logic [AW:0]      w_step_inc;
    logic [AW:0]      w_len_clamp;

    // In RUN, step < seq_len <= DEPTH, so the low AW bits always index a valid entry.
    assign w_idx       = r_step[AW-1:0];
    assign w_hit       = ((r_sync2 ^ r_tab[w_idx]) & r_mask) == '0;
    assign w_step_inc  = r_step + 1'b1;
    assign w_len_clamp = (i_seq_len > DEPTH_L) ? DEPTH_L : i_seq_len;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_bus_in;
            r_sync2 <= r_sync1;
        end
    end

    // The table is not reset, so that it survives a reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && (r_state != S_RUN) && ({1'b0, i_wr_addr} < DEPTH_L)) begin
            r_tab[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_len   <= '0;
            r_mask  <= '0;
            r_tmo   <= '0;
            r_tmr   <= '0;
            r_stb   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_step  <= w_step_nx;
            r_len   <= w_len_nx;
            r_mask  <= w_mask_nx;
            r_tmo   <= w_tmo_nx;
            r_tmr   <= w_tmr_nx;
            r_stb   <= w_stb_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_step_nx  = r_step;
        w_len_nx   = r_len;
        w_mask_nx  = r_mask;
        w_tmo_nx   = r_tmo;
        w_tmr_nx   = r_tmr;
        w_stb_nx   = 1'b0;

        if (i_abort) begin
            w_state_nx = S_IDLE;
            w_step_nx  = '0;
            w_tmr_nx   = '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    // A match is tested first, so it wins over a timeout in the same cycle.
                    if (w_hit) begin
                        w_stb_nx  = 1'b1;
                        w_step_nx = w_step_inc;
                        w_tmr_nx  = r_tmo;
                        if (w_step_inc == r_len) begin
                            w_state_nx = S_PASS;
                        end
                    end else if (r_tmo != '0) begin
                        if (r_tmr == TMO_W'(1)) begin
                            w_state_nx = S_FAIL;
                        end else begin
                            w_tmr_nx = r_tmr - 1'b1;
                        end
                    end
                end
                default: begin
                    if (i_start) begin
                        w_len_nx   = w_len_clamp;
                        w_mask_nx  = i_mask;
                        w_tmo_nx   = i_timeout;
                        w_tmr_nx   = i_timeout;
                        w_step_nx  = '0;
                        w_state_nx = (w_len_clamp == '0) ? S_PASS : S_RUN;
                    end
                end
            endcase
        end
    end

    assign o_busy      = (r_state == S_RUN);
    assign o_pass      = (r_state == S_PASS);
    assign o_fail      = (r_state == S_FAIL);
    assign o_step      = r_step;
    assign o_match_stb = r_stb;

endmodule

// File: tb/tb_io_seq_checker.sv
// Bench for io_seq_checker. A behavioural model predicts the status every
// cycle. Directed sequences carry hand-computed expectations that pin down
// latency, timeout length and match counts.
module tb_io_seq_checker;
    localparam int WIDTH = 8;
    localparam int DEPTH = 12;
    localparam int TMO_W = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int SW    = AW + 1;

    localparam int MI = 0;
    localparam int MR = 1;
    localparam int MP = 2;
    localparam int MF = 3;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [SW-1:0]    seq_len = '0;
    logic [WIDTH-1:0] mask = '0;
    logic [TMO_W-1:0] timeout = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] bus_in = '0;
    logic             o_busy, o_pass, o_fail, o_match_stb;
    logic [SW-1:0]    o_step;

    int vectors = 0;
    int miscompares = 0;
    int stb_cnt = 0;
    bit chk_on = 1'b0;

    logic [7:0] v_seq [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                               8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};

    // model state
    int         m_mode = MI;
    int         m_prev = MI;
    int         m_step = 0;
    int         m_wait = 0;
    int         m_len = 0;
    int         m_tmo = 0;
    logic [7:0] m_mask = '0;
    logic [7:0] m_tab [DEPTH];
    logic [7:0] m_pipe [2] = '{8'h00, 8'h00};
    logic [7:0] m_seen = '0;
    logic       m_stb = 1'b0;

    io_seq_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TMO_W(TMO_W)) dut (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_seq_len   (seq_len),
        .i_mask      (mask),
        .i_timeout   (timeout),
        .i_start     (start),
        .i_abort     (abort),
        .i_bus_in    (bus_in),
        .o_busy      (o_busy),
        .o_pass      (o_pass),
        .o_fail      (o_fail),
        .o_step      (o_step),
        .o_match_stb (o_match_stb)
    );

    initial forever #5 clk = ~clk;

    // Behavioural model. The value judged at an edge is the bus as it stood
    // two edges earlier. m_wait counts non-matching cycles since the last
    // match or start.
    initial forever begin
        @(posedge clk or negedge nrst);
        if (!nrst) begin
            m_mode = MI; m_step = 0; m_wait = 0; m_stb = 1'b0;
            m_pipe[0] = 8'h00; m_pipe[1] = 8'h00;
        end else begin
            m_seen = m_pipe[0];
            m_pipe[0] = m_pipe[1];
            m_pipe[1] = bus_in;
            m_prev = m_mode;
            m_stb = 1'b0;
            if (abort) begin
                m_mode = MI; m_step = 0;
            end else if (m_mode == MR) begin
                if ((m_seen & m_mask) == (m_tab[m_step] & m_mask)) begin
                    m_stb = 1'b1;
                    m_step++;
                    m_wait = 0;
                    if (m_step == m_len) m_mode = MP;
                end else begin
                    m_wait++;
                    if (m_tmo != 0 && m_wait >= m_tmo) m_mode = MF;
                end
            end else if (start) begin
                m_len  = (int'(seq_len) > DEPTH) ? DEPTH : int'(seq_len);
                m_mask = mask;
                m_tmo  = int'(timeout);
                m_step = 0;
                m_wait = 0;
                m_mode = (m_len == 0) ? MP : MR;
            end
            if (wr_en && m_prev != MR && int'(wr_addr) < DEPTH) m_tab[wr_addr] = wr_data;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial forever begin
        logic [SW+3:0] got, exp;
        @(negedge clk);
        if (chk_on) begin
            exp = {m_mode == MR, m_mode == MP, m_mode == MF, m_stb, SW'(m_step)};
            got = {o_busy, o_pass, o_fail, o_match_stb, o_step};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL cycle t=%0t busy/pass/fail/stb/step got %b_%b_%b_%b_%0d required %b_%b_%b_%b_%0d",
                         $time, got[SW+3], got[SW+2], got[SW+1], got[SW], got[SW-1:0],
                         exp[SW+3], exp[SW+2], exp[SW+1], exp[SW], exp[SW-1:0]);
            end
            if (o_match_stb) stb_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [7:0] data);
        wr_en = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_start(input int len, input logic [7:0] msk, input int tmo);
        seq_len = SW'(len);
        mask = msk;
        timeout = TMO_W'(tmo);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present entries from..upto-1 one at a time, advancing once the checker steps.
    task automatic feed(input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            int n;
            bus_in = v_seq[i];
            n = 0;
            while (int'(o_step) <= i && n < 8) begin
                tick();
                n++;
            end
            if (int'(o_step) <= i) begin
                vectors++;
                miscompares++;
                $display("FAIL feed entry %0d: step %0d, required > %0d", i, o_step, i);
            end
        end
    endtask

    initial begin
        int n;
        tick();
        tick();
        chk("reset outputs", int'({o_busy, o_pass, o_fail, o_match_stb, o_step}), 0);
        nrst = 1'b1;
        chk_on = 1'b1;

        for (int i = 0; i < 12; i++) wr(i, v_seq[i]);
        wr(13, 8'h5A);                      // out of range, must be dropped

        // full twelve-entry sequence
        bus_in = 8'hEE;
        stb_cnt = 0;
        do_start(12, 8'hFF, 0);
        feed(0, 12);
        chk("seq pass", int'(o_pass), 1);
        chk("seq step", int'(o_step), 12);
        tick();
        chk("seq stb count", stb_cnt, 12);

        // reset at step 5, then restart from the retained table
        bus_in = 8'hEE;
        do_start(12, 8'hFF, 0);
        feed(0, 5);
        #2 nrst = 1'b0;
        #1 chk("async reset outputs", int'({o_busy, o_pass, o_fail, o_match_stb, o_step}), 0);
        tick();
        nrst = 1'b1;
        bus_in = 8'hEE;
        tick();
        stb_cnt = 0;
        do_start(12, 8'hFF, 0);
        feed(0, 12);
        chk("restart pass", int'(o_pass), 1);
        tick();
        chk("restart stb count", stb_cnt, 12);

        // table write and start during RUN are ignored
        bus_in = 8'hEE;
        do_start(12, 8'hFF, 0);
        feed(0, 3);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h99;
        start = 1'b1; seq_len = SW'(1);
        bus_in = v_seq[3];
        tick();
        wr_en = 1'b0; start = 1'b0;
        feed(3, 12);
        chk("run-write pass", int'(o_pass), 1);
        chk("run-write step", int'(o_step), 12);

        // abort mid-run, and abort beating start
        bus_in = 8'hEE;
        do_start(12, 8'hFF, 0);
        feed(0, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort status", int'({o_busy, o_pass, o_fail, o_step}), 0);
        abort = 1'b1; start = 1'b1; seq_len = SW'(12);
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort over start busy", int'(o_busy), 0);

        // timeout 100 after the step-2 match; the held value differs from
        // entry 2 (03) so that no further match can occur
        bus_in = 8'hEE;
        do_start(12, 8'hFF, 100);
        feed(0, 2);
        bus_in = 8'hEE;
        n = 0;
        while (!o_fail && n < 300) begin
            tick();
            n++;
        end
        chk("timeout cycles", n, 100);
        chk("timeout step", int'(o_step), 2);

        // seq_len above DEPTH clamps to DEPTH; start accepted from FAIL
        bus_in = 8'hEE;
        do_start(20, 8'hFF, 0);
        feed(0, 12);
        chk("clamp pass", int'(o_pass), 1);
        chk("clamp step", int'(o_step), 12);

        // seq_len = 0 passes on the start edge with no strobe
        tick();
        stb_cnt = 0;
        do_start(0, 8'hFF, 0);
        chk("len0 pass/stb/step", int'({o_pass, o_match_stb, o_step}), 2 ** (SW + 1));
        tick();
        chk("len0 stb count", stb_cnt, 0);

        // one held value matches three equal entries on consecutive cycles
        wr(0, 8'h33); wr(1, 8'h33); wr(2, 8'h33);
        bus_in = 8'h33;
        tick();
        tick();
        stb_cnt = 0;
        do_start(3, 8'hFF, 0);
        n = 0;
        while (!o_pass && n < 10) begin
            tick();
            n++;
        end
        chk("dup entries cycles", n, 3);
        tick();
        chk("dup entries stb count", stb_cnt, 3);

        // masked compare: A5 vs 15 under 0F matches, A6 never does
        wr(0, 8'h15);
        bus_in = 8'h00;
        tick();
        tick();
        bus_in = 8'hA5;
        do_start(1, 8'h0F, 0);
        n = 0;
        while (!o_pass && n < 10) begin
            tick();
            n++;
        end
        chk("mask match latency", n, 2);
        bus_in = 8'hA6;
        tick();
        tick();
        do_start(1, 8'h0F, 20);
        n = 0;
        while (!o_fail && n < 50) begin
            tick();
            n++;
        end
        chk("mask miss timeout", n, 20);
        chk("mask miss step", int'(o_step), 0);

        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
